// File: rtl/draw_bus_pkg.sv
// Shared draw-bus definitions: word codes, pattern modes, default width.
// Used by the pattern generator and the bus receiver.
package draw_bus_pkg;

    localparam int COORD_W_DEF = 11;

    localparam logic [3:0] CODE_X      = 4'b0000;
    localparam logic [3:0] CODE_Y_MOVE = 4'b0010;
    localparam logic [3:0] CODE_Y_DRAW = 4'b0011;

    typedef enum logic [1:0] {
        MODE_SEG  = 2'd0,
        MODE_RECT = 2'd1,
        MODE_POLY = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // The reserved encoding behaves as a segment sweep.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_SEG : mode_e'(m);
    endfunction

endpackage

// File: rtl/draw_word_tx.sv
// Draw-bus word transmitter: LRFD/LDAV handshake for one word at a time.
// DATA is loaded on leaving WAIT_RDY and held until the next word.
module draw_word_tx #(
    parameter int COORD_W   = 11,
    parameter int SETUP_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [COORD_W+3:0]   word,
    output logic                 ack,
    output logic                 commit,
    input  logic                 LRFD,
    output logic                 LDAV,
    output logic [COORD_W+3:0]   DATA
);

    localparam int CW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [CW-1:0] SETUP_LAST =
        CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);

    localparam logic [1:0] T_WAIT   = 2'd0;
    localparam logic [1:0] T_SETUP  = 2'd1;
    localparam logic [1:0] T_ASSERT = 2'd2;
    localparam logic [1:0] T_REL    = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // Once LDAV is low the word is committed and must finish.
    assign ack    = (state == T_REL);
    assign commit = (state == T_ASSERT) || (state == T_REL);

    // Handshake sequencing; LDAV is released asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= T_WAIT;
            cnt   <= '0;
            LDAV  <= 1'b1;
            DATA  <= '0;
        end else begin
            case (state)
                T_WAIT: begin
                    if (valid && !LRFD) begin
                        DATA <= word;
                        cnt  <= '0;
                        if (SETUP_CYC == 0) begin
                            LDAV  <= 1'b0;
                            state <= T_ASSERT;
                        end else begin
                            state <= T_SETUP;
                        end
                    end
                end
                T_SETUP: begin
                    if (!valid) begin
                        state <= T_WAIT;
                    end else if (cnt == SETUP_LAST) begin
                        LDAV  <= 1'b0;
                        state <= T_ASSERT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                T_ASSERT: begin
                    if (LRFD) begin
                        LDAV  <= 1'b1;
                        state <= T_REL;
                    end
                end
                default: begin
                    state <= T_WAIT;
                end
            endcase
        end
    end

endmodule

// File: rtl/draw_pattern_gen.sv
// Vector-pattern source for the draw bus: segment, rectangle, polyline.
// Sequences words and coordinates; draw_word_tx performs the handshake.
module draw_pattern_gen
    import draw_bus_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEF,
    parameter int CNT_W     = 32,
    parameter int SETUP_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic                 continuous,
    input  logic [CNT_W-1:0]     count,
    input  logic [COORD_W-1:0]   x0,
    input  logic [COORD_W-1:0]   y0,
    input  logic [COORD_W-1:0]   x1,
    input  logic [COORD_W-1:0]   y1,
    input  logic [COORD_W-1:0]   dx0,
    input  logic [COORD_W-1:0]   dy0,
    input  logic [COORD_W-1:0]   dx1,
    input  logic [COORD_W-1:0]   dy1,
    input  logic                 LRFD,
    output logic                 LDAV,
    output logic [COORD_W+3:0]   DATA,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pkt_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_STEP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state;
    mode_e              mode_r;
    logic               cont_r;
    logic [CNT_W-1:0]   count_r;
    logic [COORD_W-1:0] ix0, iy0, ix1, iy1;
    logic [COORD_W-1:0] cx0, cy0, cx1, cy1;
    logic [COORD_W-1:0] sx0, sy0, sx1, sy1;
    logic [3:0]         widx;
    logic               abort_seen;

    logic [3:0]         code;
    logic [COORD_W-1:0] coord;
    logic [3:0]         last_idx;
    logic               stop;
    logic               wrap;
    logic [CNT_W-1:0]   nxt_cnt;
    logic               tx_valid;
    logic               tx_ack;
    logic               tx_commit;

    assign busy     = (state == S_LOAD) || (state == S_SEND) ||
                      (state == S_STEP);
    assign done     = (state == S_DONE);
    assign stop     = abort || abort_seen;
    assign tx_valid = (state == S_SEND) && !stop;
    assign last_idx = (mode_r == MODE_RECT) ? 4'd9 : 4'd3;
    assign nxt_cnt  = pkt_cnt + CNT_W'(1);
    assign wrap     = (nxt_cnt == count_r);

    // Word table: rectangle walks its corners, others share the segment
    // layout (polyline starts at index 2 after its first packet).
    always_comb begin
        code  = CODE_X;
        coord = cx0;
        if (mode_r == MODE_RECT) begin
            case (widx)
                4'd0: coord = cx0;
                4'd1: begin code = CODE_Y_MOVE; coord = cy0; end
                4'd2: coord = cx1;
                4'd3: begin code = CODE_Y_DRAW; coord = cy0; end
                4'd4: coord = cx1;
                4'd5: begin code = CODE_Y_DRAW; coord = cy1; end
                4'd6: coord = cx0;
                4'd7: begin code = CODE_Y_DRAW; coord = cy1; end
                4'd8: coord = cx0;
                default: begin code = CODE_Y_DRAW; coord = cy0; end
            endcase
        end else begin
            case (widx)
                4'd0: coord = cx0;
                4'd1: begin code = CODE_Y_MOVE; coord = cy0; end
                4'd2: coord = cx1;
                default: begin code = CODE_Y_DRAW; coord = cy1; end
            endcase
        end
    end

    // Run sequencer: config capture, word index, stepping and counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mode_r     <= MODE_SEG;
            cont_r     <= 1'b0;
            count_r    <= '0;
            ix0 <= '0; iy0 <= '0; ix1 <= '0; iy1 <= '0;
            cx0 <= '0; cy0 <= '0; cx1 <= '0; cy1 <= '0;
            sx0 <= '0; sy0 <= '0; sx1 <= '0; sy1 <= '0;
            widx       <= '0;
            abort_seen <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_LOAD;
                end
                S_LOAD: begin
                    mode_r     <= norm_mode(mode);
                    cont_r     <= continuous;
                    count_r    <= count;
                    ix0 <= x0; iy0 <= y0; ix1 <= x1; iy1 <= y1;
                    cx0 <= x0; cy0 <= y0; cx1 <= x1; cy1 <= y1;
                    sx0 <= dx0; sy0 <= dy0; sx1 <= dx1; sy1 <= dy1;
                    widx       <= '0;
                    abort_seen <= 1'b0;
                    pkt_cnt    <= '0;
                    if (abort || count == '0) state <= S_DONE;
                    else                      state <= S_SEND;
                end
                S_SEND: begin
                    if (pkt_cnt == count_r) pkt_cnt <= '0;
                    if (abort) abort_seen <= 1'b1;
                    if (stop && !tx_commit) begin
                        state <= S_DONE;
                    end else if (tx_ack) begin
                        if (stop)                  state <= S_DONE;
                        else if (widx == last_idx) state <= S_STEP;
                        else                       widx  <= widx + 4'd1;
                    end
                end
                S_STEP: begin
                    cx1 <= cx1 + sx1;
                    cy1 <= cy1 + sy1;
                    if (mode_r != MODE_POLY) begin
                        cx0 <= cx0 + sx0;
                        cy0 <= cy0 + sy0;
                    end
                    widx    <= (mode_r == MODE_POLY) ? 4'd2 : 4'd0;
                    pkt_cnt <= nxt_cnt;
                    if (wrap && cont_r) begin
                        cx0 <= ix0; cy0 <= iy0; cx1 <= ix1; cy1 <= iy1;
                        widx <= '0;
                    end
                    if (stop || (wrap && !cont_r)) state <= S_DONE;
                    else                           state <= S_SEND;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    draw_word_tx #(
        .COORD_W   (COORD_W),
        .SETUP_CYC (SETUP_CYC)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .valid  (tx_valid),
        .word   ({code, coord}),
        .ack    (tx_ack),
        .commit (tx_commit),
        .LRFD   (LRFD),
        .LDAV   (LDAV),
        .DATA   (DATA)
    );

endmodule

// File: tb/tb_draw_pattern_gen.sv
// Directed testbench for draw_pattern_gen.
// Second instance uses a three-cycle data setup.
module tb_draw_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start_b = 1'b0;
    logic        abort = 1'b0, abort_b = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        continuous = 1'b0;
    logic [31:0] count = 32'd0;
    logic [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [10:0] dx0 = '0, dy0 = '0, dx1 = '0, dy1 = '0;
    logic        slow = 1'b0, lrfd_force = 1'b0;
    logic        lrfd, lrfd_b, ldav, ldav_b;
    logic [14:0] data, data_b;
    logic        busy, busy_b, done, done_b;
    logic [31:0] pkt_cnt, pkt_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign lrfd   = slow ? lrfd_force : ~ldav;
    assign lrfd_b = ~ldav_b;

    draw_pattern_gen #(.COORD_W(11), .CNT_W(32), .SETUP_CYC(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mode(mode), .continuous(continuous), .count(count),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .dx0(dx0), .dy0(dy0), .dx1(dx1), .dy1(dy1),
        .LRFD(lrfd), .LDAV(ldav), .DATA(data),
        .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
    );

    draw_pattern_gen #(.COORD_W(11), .CNT_W(32), .SETUP_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .mode(mode), .continuous(continuous), .count(count),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .dx0(dx0), .dy0(dy0), .dx1(dx1), .dy1(dy1),
        .LRFD(lrfd_b), .LDAV(ldav_b), .DATA(data_b),
        .busy(busy_b), .done(done_b), .pkt_cnt(pkt_cnt_b)
    );

    // Bus monitor
    int          cyc = 0;
    logic        prev_ldav = 1'b1, prev_ldav_b = 1'b1;
    logic [14:0] prev_data = '0, prev_data_b = '0;
    logic [31:0] prev_pkt = '0;
    logic [14:0] words [$];
    int          fall_cyc [$];
    int          gap_b [$];
    int          rise_cnt = 0, last_rise = 0;
    int          done_cnt = 0, done_cyc = 0;
    int          unstable = 0, wrap_seen = 0, chg_b = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_ldav && !ldav) begin
            words.push_back(data);
            fall_cyc.push_back(cyc);
        end
        if (!prev_ldav && ldav) begin
            rise_cnt = rise_cnt + 1;
            last_rise = cyc;
        end
        if (!prev_ldav && !ldav && data !== prev_data)
            unstable = unstable + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (prev_pkt == 32'd3 && pkt_cnt == 32'd0)
            wrap_seen = wrap_seen + 1;
        prev_ldav = ldav;
        prev_data = data;
        prev_pkt  = pkt_cnt;
        if (data_b !== prev_data_b) chg_b = cyc;
        if (prev_ldav_b && !ldav_b) gap_b.push_back(cyc - chg_b);
        prev_ldav_b = ldav_b;
        prev_data_b = data_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (done) ok = 1'b1;
            else      tick();
        end
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic c,
                           input logic [31:0] n,
                           input logic [10:0] a, b, p, q,
                           input logic [10:0] da, db, dp, dq);
        mode = m; continuous = c; count = n;
        x0 = a; y0 = b; x1 = p; y1 = q;
        dx0 = da; dy0 = db; dx1 = dp; dy1 = dq;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (ldav !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ldav=%b busy=%b done=%b want 1 0 0",
                     ldav, busy, done);
        end
        checks++;
        if (data !== 15'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0000", data);
        end
        checks++;
        if (pkt_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_pkt got %0d want 0", pkt_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_segment();
        logic [14:0] e [8];
        int base, d0;
        bit ok;
        e = '{15'h000, 15'h1000, 15'h1F4, 15'h19F4,
              15'h009, 15'h100D, 15'h205, 15'h1A0B};
        set_cfg(2'd0, 1'b0, 32'd2, 11'd0, 11'd0, 11'd500, 11'd500,
                11'd9, 11'd13, 11'd17, 11'd23);
        base = words.size();
        d0 = done_cnt;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL seg_busy_load got %b want 1", busy);
        end
        wait_done(400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL seg_timeout got no done want done");
        end
        tick();
        checks++;
        if (words.size() - base != 8) begin
            errors++;
            $display("FAIL seg_nwords got %0d want 8", words.size() - base);
        end
        for (int i = 0; i < 8; i++) begin
            if (base + i < words.size()) begin
                checks++;
                if (words[base+i] !== e[i]) begin
                    errors++;
                    $display("FAIL seg_word%0d got %h want %h",
                             i, words[base+i], e[i]);
                end
            end
        end
        checks++;
        if (pkt_cnt !== 32'd2) begin
            errors++;
            $display("FAIL seg_pkt got %0d want 2", pkt_cnt);
        end
        checks++;
        if (done_cyc != last_rise + 2 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL seg_done got cyc=%0d n=%0d want cyc=%0d n=1",
                     done_cyc, done_cnt - d0, last_rise + 2);
        end
        if (words.size() - base >= 2) begin
            checks++;
            if (fall_cyc[base+1] - fall_cyc[base] != 4) begin
                errors++;
                $display("FAIL seg_period got %0d want 4",
                         fall_cyc[base+1] - fall_cyc[base]);
            end
        end
        checks++;
        if (data !== 15'h1A0B || busy !== 1'b0) begin
            errors++;
            $display("FAIL seg_idle got data=%h busy=%b want 1a0b 0",
                     data, busy);
        end
    endtask

    task automatic test_rectangle();
        logic [14:0] e [10];
        int base;
        bit ok;
        e = '{15'h00A, 15'h1014, 15'h01E, 15'h1814, 15'h01E,
              15'h1828, 15'h00A, 15'h1828, 15'h00A, 15'h1814};
        set_cfg(2'd1, 1'b0, 32'd1, 11'd10, 11'd20, 11'd30, 11'd40,
                11'd0, 11'd0, 11'd0, 11'd0);
        base = words.size();
        pulse_start();
        wait_done(400, ok);
        tick();
        checks++;
        if (!ok || words.size() - base != 10) begin
            errors++;
            $display("FAIL rect_nwords got %0d done=%b want 10 1",
                     words.size() - base, ok);
        end
        for (int i = 0; i < 10; i++) begin
            if (base + i < words.size()) begin
                checks++;
                if (words[base+i] !== e[i]) begin
                    errors++;
                    $display("FAIL rect_word%0d got %h want %h",
                             i, words[base+i], e[i]);
                end
            end
        end
        checks++;
        if (pkt_cnt !== 32'd1) begin
            errors++;
            $display("FAIL rect_pkt got %0d want 1", pkt_cnt);
        end
    endtask

    task automatic test_mode3();
        logic [14:0] e [4];
        int base;
        bit ok;
        e = '{15'h001, 15'h1002, 15'h003, 15'h1804};
        set_cfg(2'd3, 1'b0, 32'd1, 11'd1, 11'd2, 11'd3, 11'd4,
                11'd0, 11'd0, 11'd0, 11'd0);
        base = words.size();
        pulse_start();
        wait_done(200, ok);
        tick();
        checks++;
        if (!ok || words.size() - base != 4) begin
            errors++;
            $display("FAIL mode3_nwords got %0d want 4", words.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            if (base + i < words.size()) begin
                checks++;
                if (words[base+i] !== e[i]) begin
                    errors++;
                    $display("FAIL mode3_word%0d got %h want %h",
                             i, words[base+i], e[i]);
                end
            end
        end
    endtask

    task automatic test_poly_continuous();
        logic [14:0] e [12];
        int base, w0, n;
        bit ok;
        e = '{15'h005, 15'h1006, 15'h064, 15'h18C8, 15'h065, 15'h18C8,
              15'h066, 15'h18C8, 15'h005, 15'h1006, 15'h064, 15'h18C8};
        set_cfg(2'd2, 1'b1, 32'd3, 11'd5, 11'd6, 11'd100, 11'd200,
                11'd7, 11'd7, 11'd1, 11'd0);
        base = words.size();
        w0 = wrap_seen;
        pulse_start();
        n = 0;
        while (words.size() - base < 12 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (words.size() - base < 12) begin
            errors++;
            $display("FAIL poly_timeout got %0d words want 12",
                     words.size() - base);
        end
        for (int i = 0; i < 12; i++) begin
            if (base + i < words.size()) begin
                checks++;
                if (words[base+i] !== e[i]) begin
                    errors++;
                    $display("FAIL poly_word%0d got %h want %h",
                             i, words[base+i], e[i]);
                end
            end
        end
        checks++;
        if (wrap_seen - w0 != 1 || pkt_cnt !== 32'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL poly_wrap got wraps=%0d pkt=%0d busy=%b want 1 0 1",
                     wrap_seen - w0, pkt_cnt, busy);
        end
        abort = 1'b1;
        wait_done(100, ok);
        abort = 1'b0;
        tick();
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL poly_abort got done=%b busy=%b want 1 0", ok, busy);
        end
    endtask

    task automatic test_wrap();
        int base;
        bit ok;
        set_cfg(2'd2, 1'b0, 32'd2, 11'd1, 11'd1, 11'd2047, 11'd9,
                11'd0, 11'd0, 11'd1, 11'd0);
        base = words.size();
        pulse_start();
        wait_done(200, ok);
        tick();
        checks++;
        if (!ok || words.size() - base != 6) begin
            errors++;
            $display("FAIL wrap_nwords got %0d want 6", words.size() - base);
        end else begin
            checks++;
            if (words[base+2] !== 15'h7FF || words[base+4] !== 15'h000) begin
                errors++;
                $display("FAIL wrap_coord got %h %h want 07ff 0000",
                         words[base+2], words[base+4]);
            end
        end
        checks++;
        if (pkt_cnt !== 32'd2) begin
            errors++;
            $display("FAIL wrap_pkt got %0d want 2", pkt_cnt);
        end
    endtask

    task automatic test_count_zero();
        int base;
        set_cfg(2'd0, 1'b1, 32'd0, 11'd3, 11'd3, 11'd3, 11'd3,
                11'd0, 11'd0, 11'd0, 11'd0);
        base = words.size();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL cnt0_load got busy=%b done=%b want 1 0", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cnt0_done got done=%b busy=%b want 1 0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL cnt0_pulse got done=%b want 0", done);
        end
        repeat (5) tick();
        checks++;
        if (words.size() != base || pkt_cnt !== 32'd0) begin
            errors++;
            $display("FAIL cnt0_words got %0d pkt=%0d want 0 0",
                     words.size() - base, pkt_cnt);
        end
    endtask

    task automatic test_abort_wait();
        int base;
        bit ok;
        slow = 1'b1;
        lrfd_force = 1'b1;
        set_cfg(2'd0, 1'b0, 32'd4, 11'd1, 11'd1, 11'd1, 11'd1,
                11'd0, 11'd0, 11'd0, 11'd0);
        base = words.size();
        pulse_start();
        repeat (5) tick();
        abort = 1'b1;
        wait_done(10, ok);
        abort = 1'b0;
        tick();
        checks++;
        if (!ok || words.size() != base || ldav !== 1'b1) begin
            errors++;
            $display("FAIL abort_wait got done=%b words=%0d ldav=%b want 1 0 1",
                     ok, words.size() - base, ldav);
        end
        slow = 1'b0;
        tick();
    endtask

    task automatic test_slow_abort();
        int base, r0, d0, n;
        bit ok;
        slow = 1'b1;
        lrfd_force = 1'b0;
        set_cfg(2'd0, 1'b0, 32'd5, 11'd4, 11'd4, 11'd8, 11'd8,
                11'd1, 11'd1, 11'd1, 11'd1);
        base = words.size();
        r0 = rise_cnt;
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (ldav !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (ldav !== 1'b0) begin
            errors++;
            $display("FAIL slow_ldav_fall got %b want 0", ldav);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 10) abort = 1'b1;
            tick();
        end
        checks++;
        if (ldav !== 1'b0 || done_cnt != d0) begin
            errors++;
            $display("FAIL slow_hold got ldav=%b dones=%0d want 0 0",
                     ldav, done_cnt - d0);
        end
        lrfd_force = 1'b1;
        wait_done(10, ok);
        abort = 1'b0;
        tick();
        slow = 1'b0;
        repeat (20) tick();
        checks++;
        if (!ok || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL slow_done got %0d pulses want 1", done_cnt - d0);
        end
        checks++;
        if (words.size() - base != 1 || rise_cnt - r0 != 1) begin
            errors++;
            $display("FAIL slow_words got falls=%0d rises=%0d want 1 1",
                     words.size() - base, rise_cnt - r0);
        end
        checks++;
        if (pkt_cnt !== 32'd0) begin
            errors++;
            $display("FAIL slow_pkt got %0d want 0", pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        slow = 1'b1;
        lrfd_force = 1'b0;
        set_cfg(2'd0, 1'b0, 32'd5, 11'd2, 11'd2, 11'd2, 11'd2,
                11'd0, 11'd0, 11'd0, 11'd0);
        pulse_start();
        n = 0;
        while (ldav !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (n >= 20 || ldav !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got ldav=%b busy=%b want 1 0", ldav, busy);
        end
        tick();
        rst = 1'b0;
        slow = 1'b0;
        tick();
    endtask

    task automatic test_setup3();
        int nb, n;
        set_cfg(2'd0, 1'b0, 32'd1, 11'h55, 11'h66, 11'h77, 11'h88,
                11'd0, 11'd0, 11'd0, 11'd0);
        nb = gap_b.size();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (gap_b.size() - nb != 4) begin
            errors++;
            $display("FAIL setup3_nwords got %0d want 4", gap_b.size() - nb);
        end
        for (int i = 0; i < 4; i++) begin
            if (nb + i < gap_b.size()) begin
                checks++;
                if (gap_b[nb+i] != 3) begin
                    errors++;
                    $display("FAIL setup3_gap%0d got %0d want 3",
                             i, gap_b[nb+i]);
                end
            end
        end
        checks++;
        if (pkt_cnt_b !== 32'd1 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL setup3_end got pkt=%0d busy=%b want 1 0",
                     pkt_cnt_b, busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_segment();
        test_rectangle();
        test_mode3();
        test_poly_continuous();
        test_wrap();
        test_count_zero();
        test_abort_wait();
        test_slow_abort();
        test_reset_mid();
        test_setup3();
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL data_stable got %0d changes want 0", unstable);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
